// File: rtl/btime_upload_pkg.sv
// Shared types and helpers for the SDRAM-to-data_io upload reader.
package btime_upload_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Byte lane within a 16-bit SDRAM word, selected by byte address bit 0
   localparam logic LO_LANE = 1'b0;
   localparam logic HI_LANE = 1'b1;

   // Even byte lives in [7:0], odd byte in [15:8] (ds = {addr[0], ~addr[0]})
   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
      return (lane == LO_LANE) ? word[7:0] : word[15:8];
   endfunction

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// SDRAM toggle-handshake read port: req toggles, ack follows with data.
interface ioctl_upload_reader_if #(
   parameter int unsigned ADDR_W = 23
);
   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-2:0] mem_addr;
   logic [15:0]       mem_dout;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_dout);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_dout);
endinterface

// File: rtl/upload_word_fetch.sv
// Toggle req/ack engine: one outstanding word read, ack detect, ack timeout.
module upload_word_fetch
   import btime_upload_pkg::*;
#(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  issue,
   input  logic [ADDR_W-2:0]     issue_addr,
   output logic                  pending,
   output logic                  ack_c,
   output logic [15:0]           rd_data_c,
   output logic                  timeout_c,
   ioctl_upload_reader_if.master mem
);

   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic              req_q, req_d;
   logic [ADDR_W-2:0] addr_q, addr_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Handshake state registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         req_q     <= 1'b0;
         addr_q    <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         req_q     <= req_d;
         addr_q    <= addr_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   // Ack detect, saturating timeout counter and request issue
   always_comb begin
      req_d     = req_q;
      addr_d    = addr_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      ack_c     = pending_q && (mem.mem_ack == req_q);
      timeout_c = pending_q && !ack_c && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

      if (ack_c) begin
         pending_d = 1'b0;
      end else if (pending_q && (cnt_q != CNT_W'(ACK_TIMEOUT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (issue && !pending_q) begin
         req_d     = ~req_q;
         addr_d    = issue_addr;
         pending_d = 1'b1;
         cnt_d     = '0;
      end
   end

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;
   assign pending      = pending_q;
   assign rd_data_c    = mem.mem_dout;

endmodule

// File: rtl/ioctl_upload_reader.sv
// Streams a byte range out of SDRAM to data_io, prefetching one word ahead.
module ioctl_upload_reader
   import btime_upload_pkg::*;
#(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned LEN_W       = 17,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  ioctl_upload,
   input  logic                  ioctl_rd,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [LEN_W-1:0]      length,
   output logic [7:0]            ioctl_din,
   output logic                  ioctl_ready,
   output logic [ADDR_W-1:0]     byte_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   ioctl_upload_reader_if.master mem
);

   state_e            state_q, state_d;
   logic              upload_q;
   logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [15:0]       cur_q, cur_d, nxt_q, nxt_d;
   logic              cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
   logic              err_q, err_d;
   logic [7:0]        din_q, din_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              rise_c, fall_c, issue_c, rd_ok_c, last_c, release_c;
   logic              pending, ack_c, timeout_c;
   logic [15:0]       rd_data_c;

   upload_word_fetch #(
      .ADDR_W      (ADDR_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_fetch (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .issue      (issue_c),
      .issue_addr (fetch_addr_q[ADDR_W-1:1]),
      .pending    (pending),
      .ack_c      (ack_c),
      .rd_data_c  (rd_data_c),
      .timeout_c  (timeout_c),
      .mem        (mem)
   );

   // State, buffers, counters and registered outputs
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         upload_q     <= 1'b0;
         byte_addr_q  <= '0;
         fetch_addr_q <= '0;
         end_q        <= '0;
         remaining_q  <= '0;
         cur_q        <= '0;
         nxt_q        <= '0;
         cur_v_q      <= 1'b0;
         nxt_v_q      <= 1'b0;
         err_q        <= 1'b0;
         din_q        <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         upload_q     <= ioctl_upload;
         byte_addr_q  <= byte_addr_d;
         fetch_addr_q <= fetch_addr_d;
         end_q        <= end_d;
         remaining_q  <= remaining_d;
         cur_q        <= cur_d;
         nxt_q        <= nxt_d;
         cur_v_q      <= cur_v_d;
         nxt_v_q      <= nxt_v_d;
         err_q        <= err_d;
         din_q        <= din_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state, word buffer management and byte presentation
   always_comb begin
      state_d      = state_q;
      byte_addr_d  = byte_addr_q;
      fetch_addr_d = fetch_addr_q;
      end_d        = end_q;
      remaining_d  = remaining_q;
      cur_d        = cur_q;
      nxt_d        = nxt_q;
      cur_v_d      = cur_v_q;
      nxt_v_d      = nxt_v_q;
      err_d        = err_q;

      rise_c    = ioctl_upload && !upload_q;
      fall_c    = !ioctl_upload && upload_q;
      rd_ok_c   = (state_q == RUN) && ioctl_rd && ready_q;
      last_c    = rd_ok_c && (remaining_q == LEN_W'(1));
      release_c = rd_ok_c && ((byte_addr_q[0] == HI_LANE) || (remaining_q == LEN_W'(1)));
      issue_c   = (state_q == RUN) && !fall_c && !pending && !nxt_v_q && (fetch_addr_q < end_q);

      case (state_q)
         IDLE: begin
            if (rise_c) begin
               err_d = 1'b0;
               if (length != '0) begin
                  state_d      = RUN;
                  byte_addr_d  = base_addr;
                  remaining_d  = length;
                  fetch_addr_d = {base_addr[ADDR_W-1:1], 1'b0};
                  end_d        = base_addr + ADDR_W'(length);
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (ioctl_rd && !ready_q) begin
               err_d = 1'b1;
            end
            if (rd_ok_c) begin
               byte_addr_d = byte_addr_q + ADDR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
            end
            // A released word is replaced by nxt, else by same-cycle ack data
            if (release_c) begin
               if (nxt_v_q) begin
                  cur_d   = nxt_q;
                  nxt_v_d = 1'b0;
               end else if (ack_c) begin
                  cur_d = rd_data_c;
               end else begin
                  cur_v_d = 1'b0;
               end
            end else if (ack_c) begin
               if (!cur_v_q) begin
                  cur_d   = rd_data_c;
                  cur_v_d = 1'b1;
               end else begin
                  nxt_d   = rd_data_c;
                  nxt_v_d = 1'b1;
               end
            end
            if (ack_c) begin
               fetch_addr_d = fetch_addr_q + ADDR_W'(2);
            end
            if (last_c && (!pending || ack_c)) begin
               state_d = DONE;
            end else if ((remaining_q == '0) && !pending) begin
               state_d = DONE;
            end
         end
         DRAIN: begin
            if (ack_c) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (timeout_c) begin
         err_d = 1'b1;
      end

      // An outstanding read must be absorbed before the port is idle again
      if (fall_c) begin
         state_d = (pending && !ack_c) ? DRAIN : IDLE;
      end

      if (state_d != RUN) begin
         cur_v_d = 1'b0;
         nxt_v_d = 1'b0;
      end

      ready_d = (state_d == RUN) && cur_v_d;
      din_d   = lane_byte(cur_d, byte_addr_d[0]);
      busy_d  = (state_d == RUN) || (state_d == DRAIN);
      done_d  = (state_d == DONE);
   end

   assign ioctl_din   = din_q;
   assign ioctl_ready = ready_q;
   assign byte_addr   = byte_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader with a toggle-handshake SDRAM model.
module tb_ioctl_upload_reader;

   localparam int unsigned ADDR_W = 23;
   localparam int unsigned LEN_W  = 17;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              ioctl_upload = 1'b0;
   logic              ioctl_rd = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  length = '0;
   logic [7:0]        ioctl_din;
   logic              ioctl_ready;
   logic [ADDR_W-1:0] byte_addr;
   logic              busy, done, err;

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;
   int dly = 0;
   int toggles = 0;
   logic req_prev;
   logic [ADDR_W-2:0] addr_log [16];

   ioctl_upload_reader_if #(.ADDR_W(ADDR_W)) mem_if ();

   ioctl_upload_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACK_TIMEOUT(255)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .base_addr    (base_addr),
      .length       (length),
      .ioctl_din    (ioctl_din),
      .ioctl_ready  (ioctl_ready),
      .byte_addr    (byte_addr),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .mem          (mem_if)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [15:0] mem_word(input logic [ADDR_W-2:0] a);
      case (a)
         22'h000800: return 16'hBBAA;
         22'h000801: return 16'hDDCC;
         default:    return {a[7:0], ~a[7:0]};
      endcase
   endfunction

   // SDRAM model: acks a toggled request after ack_delay extra cycles
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mem_if.mem_ack  <= 1'b0;
         mem_if.mem_dout <= '0;
         dly             <= 0;
      end else if (mem_if.mem_req != mem_if.mem_ack) begin
         if (dly >= ack_delay) begin
            mem_if.mem_ack  <= mem_if.mem_req;
            mem_if.mem_dout <= mem_word(mem_if.mem_addr);
            dly             <= 0;
         end else begin
            dly <= dly + 1;
         end
      end
   end

   // Request toggle monitor with address log
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         req_prev <= 1'b0;
      end else begin
         req_prev <= mem_if.mem_req;
         if (mem_if.mem_req != req_prev) begin
            addr_log[toggles[3:0]] <= mem_if.mem_addr;
            toggles <= toggles + 1;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int bound);
      int n = 0;
      while (ioctl_ready !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk("ready_wait", 32'(ioctl_ready), 32'd1);
   endtask

   task automatic read_byte(input string tag, input logic [7:0] eb, input logic [ADDR_W-1:0] ea);
      wait_ready(1000);
      chk({tag, "_din"}, 32'(ioctl_din), 32'(eb));
      chk({tag, "_addr"}, 32'(byte_addr), 32'(ea));
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      tick(3);
   endtask

   task automatic start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, input int d);
      ack_delay    = d;
      base_addr    = b;
      length       = l;
      ioctl_upload = 1'b1;
      tick();
   endtask

   task automatic stop();
      ioctl_upload = 1'b0;
      tick();
   endtask

   initial begin
      int t0;
      int n;
      logic rq;

      // Reset state
      tick(3);
      chk("rst_din",   32'(ioctl_din), 32'd0);
      chk("rst_ready", 32'(ioctl_ready), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_req",   32'(mem_if.mem_req), 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Aligned 4-byte transfer
      t0 = toggles;
      start(23'h001000, 17'd4, 0);
      chk("t1_busy", 32'(busy), 32'd1);
      read_byte("t1_b0", 8'hAA, 23'h001000);
      read_byte("t1_b1", 8'hBB, 23'h001001);
      read_byte("t1_b2", 8'hCC, 23'h001002);
      read_byte("t1_b3", 8'hDD, 23'h001003);
      chk("t1_done",    32'(done), 32'd1);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_ready",   32'(ioctl_ready), 32'd0);
      chk("t1_toggles", 32'(toggles - t0), 32'd2);
      chk("t1_err",     32'(err), 32'd0);
      stop();
      chk("t1_done_clr", 32'(done), 32'd0);

      // Odd base, 2 bytes spanning two words
      t0 = toggles;
      start(23'h001001, 17'd2, 0);
      read_byte("t2_b0", 8'hBB, 23'h001001);
      chk("t2_addr0", 32'(addr_log[t0 % 16]), 32'h800);
      read_byte("t2_b1", 8'hCC, 23'h001002);
      chk("t2_done",    32'(done), 32'd1);
      chk("t2_addr1",   32'(addr_log[(t0 + 1) % 16]), 32'h801);
      chk("t2_toggles", 32'(toggles - t0), 32'd2);
      stop();

      // Odd length: final high byte never shown
      t0 = toggles;
      start(23'h001000, 17'd3, 0);
      read_byte("t3_b0", 8'hAA, 23'h001000);
      read_byte("t3_b1", 8'hBB, 23'h001001);
      read_byte("t3_b2", 8'hCC, 23'h001002);
      chk("t3_done",    32'(done), 32'd1);
      chk("t3_ready",   32'(ioctl_ready), 32'd0);
      chk("t3_toggles", 32'(toggles - t0), 32'd2);
      stop();

      // Zero length
      t0 = toggles;
      rq = mem_if.mem_req;
      start(23'h001000, 17'd0, 0);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_req",  32'(mem_if.mem_req), 32'(rq));
      tick();
      chk("t4_toggles", 32'(toggles - t0), 32'd0);
      stop();

      // Ack timeout, data still delivered afterwards
      start(23'h001000, 17'd2, 300);
      chk("t5_err_start", 32'(err), 32'd0);
      tick(240);
      chk("t5_err_early", 32'(err), 32'd0);
      tick(20);
      chk("t5_err_timeout", 32'(err), 32'd1);
      read_byte("t5_b0", 8'hAA, 23'h001000);
      read_byte("t5_b1", 8'hBB, 23'h001001);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_err_sticky", 32'(err), 32'd1);
      stop();

      // Underrun, then drop upload with a request outstanding
      start(23'h001000, 17'd4, 300);
      chk("t6_err_cleared", 32'(err), 32'd0);
      tick(5);
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      chk("t6_underrun_err", 32'(err), 32'd1);
      chk("t6_underrun_addr", 32'(byte_addr), 32'h1000);
      chk("t6_underrun_ready", 32'(ioctl_ready), 32'd0);
      t0 = toggles;
      stop();
      chk("t6_drain_busy", 32'(busy), 32'd1);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("t6_drain_exit", 32'(busy), 32'd0);
      chk("t6_no_new_req", 32'(toggles - t0), 32'd0);
      chk("t6_done", 32'(done), 32'd0);

      // Asynchronous reset mid-transfer
      start(23'h001000, 17'd4, 0);
      wait_ready(100);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t7_din",   32'(ioctl_din), 32'd0);
      chk("t7_ready", 32'(ioctl_ready), 32'd0);
      chk("t7_addr",  32'(byte_addr), 32'd0);
      chk("t7_busy",  32'(busy), 32'd0);
      chk("t7_req",   32'(mem_if.mem_req), 32'd0);
      ioctl_upload = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
